// File: rtl/dpwm_multiphase.sv
// Multi-phase DPWM: shared sawtooth, per-channel phase, dead time,
// soft-start ramp and shadow-register settings applied at the wrap.
module dpwm_multiphase #(
    parameter int N_CH = 2,
    parameter int CW   = 10,
    parameter int DTW  = 4
) (
    input  logic                 CLOCK_50,
    input  logic                 resetn,
    input  logic                 en,
    input  logic                 load,
    input  logic [CW-1:0]        maxcount,
    input  logic [CW-1:0]        duty,
    input  logic [N_CH*CW-1:0]   phase,
    input  logic [DTW-1:0]       dt_rise,
    input  logic [DTW-1:0]       dt_fall,
    input  logic                 soft_start,
    output logic [N_CH-1:0]      hi,
    output logic [N_CH-1:0]      lo,
    output logic                 period_start,
    output logic                 load_ack,
    output logic                 ss_done
);

    localparam logic [CW:0] ONE       = (CW+1)'(1);
    localparam logic [CW:0] RAMP_FULL = {1'b1, {CW{1'b0}}};

    logic [CW-1:0]       cnt;
    logic [CW-1:0]       max_act, duty_act;
    logic [N_CH*CW-1:0]  phase_act;
    logic [DTW-1:0]      dt_rise_act, dt_fall_act;
    logic [CW-1:0]       max_pnd, duty_pnd;
    logic [N_CH*CW-1:0]  phase_pnd;
    logic [DTW-1:0]      dt_rise_pnd, dt_fall_pnd;
    logic                pnd;

    logic [CW-1:0]       max_src, duty_src, max_nx, duty_nx;
    logic [N_CH*CW-1:0]  phase_raw, phase_src;
    logic [DTW-1:0]      dtr_src, dtf_src;

    logic [CW:0]         ramp, ramp_nx;
    logic [CW:0]         mp1, duty_sat, duty_eff, mp1_nx, duty_sat_nx;
    logic                wrap, apply_in, apply_pnd, apply;

    logic [N_CH-1:0]     pwm, pwm_q;
    logic [CW:0]         ch_sum [N_CH];
    logic [CW:0]         ch_cnt [N_CH];
    logic [DTW-1:0]      dcnt [N_CH];
    logic [DTW-1:0]      dcnt_nx [N_CH];

    function automatic logic [CW-1:0] sat_ph(
        input logic [CW-1:0] p,
        input logic [CW-1:0] m
    );
        return (p > m) ? m : p;
    endfunction

    assign wrap      = en && (cnt == max_act);
    assign apply_in  = load && wrap;
    assign apply_pnd = pnd && !apply_in && (wrap || !en);
    assign apply     = apply_in || apply_pnd;

    // Settings to install on apply: live inputs at a load-on-wrap, else pending bank
    always_comb begin
        max_src   = apply_in ? maxcount : max_pnd;
        duty_src  = apply_in ? duty : duty_pnd;
        dtr_src   = apply_in ? dt_rise : dt_rise_pnd;
        dtf_src   = apply_in ? dt_fall : dt_fall_pnd;
        phase_raw = apply_in ? phase : phase_pnd;
        phase_src = '0;
        for (int i = 0; i < N_CH; i++) begin
            phase_src[i*CW +: CW] = sat_ph(phase_raw[i*CW +: CW], max_src);
        end
        max_nx  = apply ? max_src : max_act;
        duty_nx = apply ? duty_src : duty_act;
    end

    // Effective duty for this cycle and for the cycle after the edge
    always_comb begin
        mp1         = {1'b0, max_act} + ONE;
        duty_sat    = ({1'b0, duty_act} < mp1) ? {1'b0, duty_act} : mp1;
        duty_eff    = (ramp < duty_sat) ? ramp : duty_sat;
        mp1_nx      = {1'b0, max_nx} + ONE;
        duty_sat_nx = ({1'b0, duty_nx} < mp1_nx) ? {1'b0, duty_nx} : mp1_nx;
    end

    // Soft-start ramp advances one count per period until it covers the duty
    always_comb begin
        if (!en) begin
            ramp_nx = '0;
        end else if (!soft_start) begin
            ramp_nx = RAMP_FULL;
        end else if (wrap && (ramp < duty_sat)) begin
            ramp_nx = ramp + ONE;
        end else begin
            ramp_nx = ramp;
        end
    end

    // Per-channel phased count, compare and dead-time reload
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            ch_sum[i] = {1'b0, cnt} + {1'b0, phase_act[i*CW +: CW]};
            ch_cnt[i] = (ch_sum[i] > {1'b0, max_act}) ? ch_sum[i] - mp1 : ch_sum[i];
            pwm[i]    = ch_cnt[i] < duty_eff;
            if (pwm[i] != pwm_q[i]) begin
                dcnt_nx[i] = pwm[i] ? dt_rise_act : dt_fall_act;
            end else if (dcnt[i] != '0) begin
                dcnt_nx[i] = dcnt[i] - DTW'(1);
            end else begin
                dcnt_nx[i] = dcnt[i];
            end
        end
    end

    // Shadow bank: capture on load, install at wrap or while disabled
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            max_act     <= '0;
            duty_act    <= '0;
            phase_act   <= '0;
            dt_rise_act <= '0;
            dt_fall_act <= '0;
            max_pnd     <= '0;
            duty_pnd    <= '0;
            phase_pnd   <= '0;
            dt_rise_pnd <= '0;
            dt_fall_pnd <= '0;
            pnd         <= 1'b0;
            load_ack    <= 1'b0;
        end else begin
            load_ack <= apply;
            if (apply) begin
                max_act     <= max_src;
                duty_act    <= duty_src;
                phase_act   <= phase_src;
                dt_rise_act <= dtr_src;
                dt_fall_act <= dtf_src;
            end
            if (load && !apply_in) begin
                max_pnd     <= maxcount;
                duty_pnd    <= duty;
                phase_pnd   <= phase;
                dt_rise_pnd <= dt_rise;
                dt_fall_pnd <= dt_fall;
                pnd         <= 1'b1;
            end else if (apply) begin
                pnd <= 1'b0;
            end
        end
    end

    // Sawtooth counter, ramp and period status flags
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            cnt          <= '0;
            ramp         <= '0;
            period_start <= 1'b0;
            ss_done      <= 1'b0;
        end else begin
            cnt          <= (!en || wrap) ? '0 : cnt + CW'(1);
            ramp         <= ramp_nx;
            period_start <= wrap;
            ss_done      <= (ramp_nx >= duty_sat_nx);
        end
    end

    // Gate outputs: follow pwm once the dead-time counter has expired
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            pwm_q <= '0;
            hi    <= '0;
            lo    <= '0;
            for (int i = 0; i < N_CH; i++) dcnt[i] <= '0;
        end else if (!en) begin
            pwm_q <= '0;
            hi    <= '0;
            lo    <= '0;
            for (int i = 0; i < N_CH; i++) dcnt[i] <= '0;
        end else begin
            pwm_q <= pwm;
            for (int i = 0; i < N_CH; i++) begin
                dcnt[i] <= dcnt_nx[i];
                hi[i]   <= (dcnt_nx[i] == '0) && pwm[i];
                lo[i]   <= (dcnt_nx[i] == '0) && !pwm[i];
            end
        end
    end

endmodule

// File: tb/tb_dpwm_multiphase.sv
// Bench for dpwm_multiphase: directed waveform checks plus
// randomized settings against a cycle-level reference model.
module tb_dpwm_multiphase;

    localparam int N_CH = 2;
    localparam int CW   = 10;
    localparam int DTW  = 4;

    logic                CLOCK_50 = 1'b0;
    logic                resetn;
    logic                en;
    logic                load;
    logic [CW-1:0]       maxcount;
    logic [CW-1:0]       duty;
    logic [N_CH*CW-1:0]  phase;
    logic [DTW-1:0]      dt_rise;
    logic [DTW-1:0]      dt_fall;
    logic                soft_start;
    logic [N_CH-1:0]     hi;
    logic [N_CH-1:0]     lo;
    logic                period_start;
    logic                load_ack;
    logic                ss_done;

    dpwm_multiphase #(.N_CH(N_CH), .CW(CW), .DTW(DTW)) dut (
        .CLOCK_50(CLOCK_50),
        .resetn(resetn),
        .en(en),
        .load(load),
        .maxcount(maxcount),
        .duty(duty),
        .phase(phase),
        .dt_rise(dt_rise),
        .dt_fall(dt_fall),
        .soft_start(soft_start),
        .hi(hi),
        .lo(lo),
        .period_start(period_start),
        .load_ack(load_ack),
        .ss_done(ss_done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // reference model state
    int m_cnt, m_ramp, m_edge;
    int a_max, a_duty, a_dtr, a_dtf;
    int p_max, p_duty, p_dtr, p_dtf;
    int a_ph [N_CH];
    int p_ph [N_CH];
    bit m_pend;
    bit m_prev [N_CH];
    int m_tchg [N_CH];
    int m_dtc  [N_CH];
    logic [N_CH-1:0] e_hi, e_lo;
    logic e_ps, e_ack, e_ss;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_ramp = 0; m_pend = 0;
        a_max = 0; a_duty = 0; a_dtr = 0; a_dtf = 0;
        p_max = 0; p_duty = 0; p_dtr = 0; p_dtf = 0;
        for (int i = 0; i < N_CH; i++) begin
            a_ph[i] = 0; p_ph[i] = 0; m_prev[i] = 0;
            m_tchg[i] = -1000; m_dtc[i] = 0;
        end
        e_hi = '0; e_lo = '0; e_ps = 0; e_ack = 0; e_ss = 0;
    endtask

    // One clock edge of the reference behaviour, using the inputs as sampled
    task automatic model_step();
        int mp1, dsat, deff, c, nramp;
        bit wrap, p, applied;
        if (!resetn) return;
        mp1  = a_max + 1;
        wrap = en && (m_cnt == a_max);
        dsat = imin(a_duty, mp1);
        deff = imin(m_ramp, dsat);
        for (int i = 0; i < N_CH; i++) begin
            c = (m_cnt + a_ph[i]) % mp1;
            p = (c < deff);
            if (!en) begin
                e_hi[i] = 0; e_lo[i] = 0;
                m_prev[i] = 0; m_tchg[i] = -1000;
            end else begin
                if (p != m_prev[i]) begin
                    m_prev[i] = p;
                    m_tchg[i] = m_edge;
                    m_dtc[i]  = p ? a_dtr : a_dtf;
                end
                if (m_edge - m_tchg[i] < m_dtc[i]) begin
                    e_hi[i] = 0; e_lo[i] = 0;
                end else begin
                    e_hi[i] = p; e_lo[i] = !p;
                end
            end
        end
        if (!en) nramp = 0;
        else if (!soft_start) nramp = 1 << CW;
        else if (wrap && m_ramp < dsat) nramp = m_ramp + 1;
        else nramp = m_ramp;
        applied = 0;
        if (load && wrap) begin
            a_max = int'(maxcount); a_duty = int'(duty);
            a_dtr = int'(dt_rise);  a_dtf = int'(dt_fall);
            for (int i = 0; i < N_CH; i++)
                a_ph[i] = imin(int'(phase[i*CW +: CW]), a_max);
            m_pend = 0; applied = 1;
        end else begin
            if (m_pend && (wrap || !en)) begin
                a_max = p_max; a_duty = p_duty; a_dtr = p_dtr; a_dtf = p_dtf;
                for (int i = 0; i < N_CH; i++) a_ph[i] = imin(p_ph[i], p_max);
                m_pend = 0; applied = 1;
            end
            if (load) begin
                p_max = int'(maxcount); p_duty = int'(duty);
                p_dtr = int'(dt_rise);  p_dtf = int'(dt_fall);
                for (int i = 0; i < N_CH; i++) p_ph[i] = int'(phase[i*CW +: CW]);
                m_pend = 1;
            end
        end
        e_ack  = applied;
        e_ps   = wrap;
        m_cnt  = (!en || wrap) ? 0 : m_cnt + 1;
        m_ramp = nramp;
        e_ss   = (m_ramp >= imin(a_duty, a_max + 1));
        m_edge++;
    endtask

    task automatic check_all();
        chk("hi", 32'(hi), 32'(e_hi));
        chk("lo", 32'(lo), 32'(e_lo));
        chk("period_start", 32'(period_start), 32'(e_ps));
        chk("load_ack", 32'(load_ack), 32'(e_ack));
        chk("ss_done", 32'(ss_done), 32'(e_ss));
        chk("overlap", 32'(hi & lo), 32'd0);
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        model_step();
        #1;
        check_all();
    endtask

    task automatic pulse_load();
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic wait_cnt(input int k);
        int n = 0;
        while (m_cnt != k && n < 50) begin
            tick();
            n++;
        end
        chk("cnt_timeout", 32'(m_cnt), 32'(k));
    endtask

    // Count gate cycles over one period window starting at period_start
    task automatic measure(output int h0, output int l0, output int h1,
                           output int l1, output int r0, output int r1,
                           output bit ss0);
        int n = 0;
        int w;
        while (!period_start && n < 60) begin
            tick();
            n++;
        end
        chk("ps_wait", 32'(period_start), 32'd1);
        w = a_max + 1;
        h0 = 0; l0 = 0; h1 = 0; l1 = 0; r0 = -1; r1 = -1;
        ss0 = ss_done;
        for (int k = 0; k < w; k++) begin
            if (k > 0) tick();
            h0 += int'(hi[0]); l0 += int'(lo[0]);
            h1 += int'(hi[1]); l1 += int'(lo[1]);
            if (hi[0] && r0 < 0) r0 = k;
            if (hi[1] && r1 < 0) r1 = k;
        end
        tick();
    endtask

    task automatic set_cfg(input int mx, input int d, input int ph0,
                           input int ph1, input int dr, input int df);
        maxcount = CW'(mx);
        duty     = CW'(d);
        phase[0 +: CW]  = CW'(ph0);
        phase[CW +: CW] = CW'(ph1);
        dt_rise  = DTW'(dr);
        dt_fall  = DTW'(df);
    endtask

    int h0, l0, h1, l1, r0, r1, nt;
    bit ssw;

    initial begin
        resetn = 1'b0; en = 1'b0; load = 1'b0; soft_start = 1'b0;
        maxcount = '0; duty = '0; phase = '0; dt_rise = '0; dt_fall = '0;
        m_edge = 0;
        model_reset();
        #12;
        check_all();
        #5 resetn = 1'b1;

        // unconfigured: one-cycle period
        en = 1'b1;
        tick(); tick();
        chk("ps_1cyc", 32'(period_start), 32'd1);

        // basic phasing
        set_cfg(9, 4, 0, 5, 0, 0);
        pulse_load();
        measure(h0, l0, h1, l1, r0, r1, ssw);
        measure(h0, l0, h1, l1, r0, r1, ssw);
        chk("basic_hi0", 32'(h0), 32'd4);
        chk("basic_lo0", 32'(l0), 32'd6);
        chk("basic_hi1", 32'(h1), 32'd4);
        chk("basic_lo1", 32'(l1), 32'd6);
        chk("basic_shift", 32'(r1 - r0), 32'd5);

        // dead time
        set_cfg(9, 4, 0, 5, 2, 3);
        pulse_load();
        measure(h0, l0, h1, l1, r0, r1, ssw);
        measure(h0, l0, h1, l1, r0, r1, ssw);
        chk("dt_hi0", 32'(h0), 32'd2);
        chk("dt_lo0", 32'(l0), 32'd3);
        chk("dt_hi1", 32'(h1), 32'd2);
        chk("dt_lo1", 32'(l1), 32'd3);

        // mid-period update
        set_cfg(9, 4, 0, 5, 0, 0);
        pulse_load();
        measure(h0, l0, h1, l1, r0, r1, ssw);
        measure(h0, l0, h1, l1, r0, r1, ssw);
        wait_cnt(3);
        duty = CW'(7);
        pulse_load();
        nt = 1;
        while (!load_ack && nt < 30) begin
            tick();
            nt++;
        end
        chk("ack_latency", 32'(nt), 32'd7);
        measure(h0, l0, h1, l1, r0, r1, ssw);
        chk("upd_hi0", 32'(h0), 32'd7);

        // double load: last wins
        wait_cnt(2);
        duty = CW'(6);
        pulse_load();
        wait_cnt(5);
        duty = CW'(8);
        pulse_load();
        measure(h0, l0, h1, l1, r0, r1, ssw);
        chk("dbl_hi0", 32'(h0), 32'd8);

        // saturation
        set_cfg(9, 12, 0, 5, 0, 0);
        pulse_load();
        measure(h0, l0, h1, l1, r0, r1, ssw);
        measure(h0, l0, h1, l1, r0, r1, ssw);
        chk("sat_hi0", 32'(h0), 32'd10);
        chk("sat_lo0", 32'(l0), 32'd0);
        chk("sat_hi1", 32'(h1), 32'd10);
        set_cfg(9, 0, 0, 5, 0, 0);
        pulse_load();
        measure(h0, l0, h1, l1, r0, r1, ssw);
        measure(h0, l0, h1, l1, r0, r1, ssw);
        chk("zero_lo0", 32'(l0), 32'd10);
        chk("zero_hi1", 32'(h1), 32'd0);
        set_cfg(9, 4, 15, 0, 0, 0);
        pulse_load();
        measure(h0, l0, h1, l1, r0, r1, ssw);
        measure(h0, l0, h1, l1, r0, r1, ssw);
        chk("ph_sat_r0", 32'(r0), 32'd2);
        chk("ph_sat_r1", 32'(r1), 32'd1);

        // soft start
        en = 1'b0;
        tick();
        soft_start = 1'b1;
        set_cfg(9, 5, 0, 5, 0, 0);
        pulse_load();
        tick(); tick();
        en = 1'b1;
        h0 = 0;
        for (int k = 0; k < 9; k++) begin
            tick();
            h0 += int'(hi[0]);
        end
        chk("ss_w0", 32'(h0), 32'd0);
        for (int w = 1; w <= 6; w++) begin
            measure(h0, l0, h1, l1, r0, r1, ssw);
            chk("ss_width", 32'(h0), 32'(imin(w, 5)));
            chk("ss_flag", 32'(ssw), 32'(w >= 5));
        end
        soft_start = 1'b0;

        // enable drop mid-pulse
        set_cfg(9, 4, 0, 5, 0, 0);
        pulse_load();
        measure(h0, l0, h1, l1, r0, r1, ssw);
        wait_cnt(2);
        en = 1'b0;
        tick();
        chk("en_off_hi", 32'(hi), 32'd0);
        chk("en_off_lo", 32'(lo), 32'd0);
        tick();
        en = 1'b1;
        nt = 0;
        while (!period_start && nt < 30) begin
            tick();
            nt++;
        end
        chk("restart", 32'(nt), 32'd10);

        // async reset mid-period
        wait_cnt(3);
        #2 resetn = 1'b0;
        #1;
        chk("rst_hi", 32'(hi), 32'd0);
        chk("rst_lo", 32'(lo), 32'd0);
        chk("rst_ack", 32'(load_ack), 32'd0);
        model_reset();
        check_all();
        tick(); tick();
        #2 resetn = 1'b1;
        tick(); tick();
        chk("rst_bank", 32'(period_start), 32'd1);

        // randomized traffic
        for (int k = 0; k < 2500; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                int mx;
                mx = $urandom_range(0, 15);
                set_cfg(mx, $urandom_range(0, mx + 3), $urandom_range(0, 20),
                        $urandom_range(0, 20), $urandom_range(0, 3),
                        $urandom_range(0, 3));
                soft_start = ($urandom_range(0, 3) == 0);
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            if ($urandom_range(0, 59) == 0) en = !en;
            tick();
            if (k == 1200) begin
                #2 resetn = 1'b0;
                #1;
                model_reset();
                check_all();
                tick();
                #2 resetn = 1'b1;
            end
        end
        load = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
